ibexc_rvfi_trace_buf: RTL and testbench

IBEXC_RVFI_TRACE_BUF -- requirements
Module: ibexc_rvfi_trace_buf

---
 rtl/ibexc_rvfi_trace_buf.sv | 131 +++++++++++++
 tb/tb_ibexc_rvfi_trace_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ibexc_rvfi_trace_buf.sv
// RVFI retirement trace FIFO with capture FSM, overflow counting and optional stop-on-trap.
// Define IBEXC_TRACE_CAP_TAG_EN to add the rd capability tag as record bit [103].
module ibexc_rvfi_trace_buf #(
    parameter int unsigned Depth      = 16,
    parameter bit          StopOnTrap = 1'b0,
`ifdef IBEXC_TRACE_CAP_TAG_EN
    localparam int unsigned RecW      = 104
`else
    localparam int unsigned RecW      = 103
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    trace_en_i,
    input  logic                    trace_clr_i,
    input  logic                    rvfi_valid_i,
    input  logic                    rvfi_trap_i,
    input  logic                    rvfi_intr_i,
    input  logic [4:0]              rvfi_rd_addr_i,
    input  logic [31:0]             rvfi_pc_rdata_i,
    input  logic [31:0]             rvfi_insn_i,
    input  logic [31:0]             rvfi_rd_wdata_i,
`ifdef IBEXC_TRACE_CAP_TAG_EN
    input  logic                    rvfi_rd_wtag_i,
`endif
    output logic                    rec_valid_o,
    input  logic                    rec_ready_i,
    output logic [RecW-1:0]         rec_data_o,
    output logic [$clog2(Depth):0]  level_o,
    output logic [15:0]             ovf_cnt_o,
    output logic                    frozen_o
);

    localparam int unsigned AW       = $clog2(Depth);
    localparam logic [AW:0] DepthCnt = (AW+1)'(Depth);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_CAPTURE,
        ST_FROZEN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d;
    logic [RecW-1:0] mem_q [Depth];

    logic            push_req, push, pop, full, mem_we;
    logic [RecW-1:0] rec_in;

    always_comb begin
`ifdef IBEXC_TRACE_CAP_TAG_EN
        rec_in = {rvfi_rd_wtag_i, rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i,
                  rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i};
`else
        rec_in = {rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i,
                  rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i};
`endif
    end

    always_comb begin
        push_req  = (state_q == ST_CAPTURE) && rvfi_valid_i;
        pop       = (level_q != '0) && rec_ready_i;
        full      = (level_q == DepthCnt);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = push_req && (!full || pop);
        mem_we    = push && !trace_clr_i;

        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_cnt_d = ovf_cnt_q;

        if (trace_clr_i) begin
            state_d   = ST_OFF;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            ovf_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req && !push && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end

            case (state_q)
                ST_OFF:     if (trace_en_i) state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    // A retiring trap freezes even when its record was dropped.
                    if (StopOnTrap && push_req && rvfi_trap_i) state_d = ST_FROZEN;
                    else if (!trace_en_i)                      state_d = ST_OFF;
                end
                ST_FROZEN:  state_d = ST_FROZEN;
                default:    state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_OFF;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage is never reset; the level counter alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= rec_in;
    end

    assign rec_valid_o = (level_q != '0);
    assign rec_data_o  = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign frozen_o    = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// Directed bench for ibexc_rvfi_trace_buf (Depth=4, StopOnTrap=1) with a queue-based reference model.
module tb_ibexc_rvfi_trace_buf;

    localparam int DEPTH = 4;
`ifdef IBEXC_TRACE_CAP_TAG_EN
    localparam int RECW = 104;
`else
    localparam int RECW = 103;
`endif

    logic            clk = 1'b0;
    logic            rst_n, en, clr, valid, trap, intr, ready, wtag;
    logic [4:0]      rd_addr;
    logic [31:0]     pc, insn, wdata;
    logic            rec_valid;
    logic [RECW-1:0] rec_data;
    logic [2:0]      level;
    logic [15:0]     ovf_cnt;
    logic            frozen;

    always #5 clk = ~clk;

    ibexc_rvfi_trace_buf #(.Depth(DEPTH), .StopOnTrap(1'b1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .trace_en_i     (en),
        .trace_clr_i    (clr),
        .rvfi_valid_i   (valid),
        .rvfi_trap_i    (trap),
        .rvfi_intr_i    (intr),
        .rvfi_rd_addr_i (rd_addr),
        .rvfi_pc_rdata_i(pc),
        .rvfi_insn_i    (insn),
        .rvfi_rd_wdata_i(wdata),
`ifdef IBEXC_TRACE_CAP_TAG_EN
        .rvfi_rd_wtag_i (wtag),
`endif
        .rec_valid_o    (rec_valid),
        .rec_ready_i    (ready),
        .rec_data_o     (rec_data),
        .level_o        (level),
        .ovf_cnt_o      (ovf_cnt),
        .frozen_o       (frozen)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of records, drop counter, and a trace mode.
    localparam int M_OFF = 0, M_CAP = 1, M_FRZ = 2;
    logic [RECW-1:0] mq[$];
    int              m_ovf  = 0;
    int              m_mode = M_OFF;
    bit              m_live = 1'b0;

    function automatic logic [RECW-1:0] cur_rec();
        logic [102:0] base;
        logic [RECW-1:0] r;
        base = {trap, intr, rd_addr, pc, insn, wdata};
        r = RECW'(base);
`ifdef IBEXC_TRACE_CAP_TAG_EN
        r[103] = wtag;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete(); m_ovf = 0; m_mode = M_OFF; m_live = 1'b1;
        end else if (m_live) begin
            if (clr) begin
                mq.delete(); m_ovf = 0; m_mode = M_OFF;
            end else begin
                bit capt;
                capt = (m_mode == M_CAP) && valid;
                if (mq.size() > 0 && ready) void'(mq.pop_front());
                if (capt) begin
                    if (mq.size() < DEPTH) mq.push_back(cur_rec());
                    else if (m_ovf < 65535) m_ovf++;
                end
                if (m_mode == M_OFF) begin
                    if (en) m_mode = M_CAP;
                end else if (m_mode == M_CAP) begin
                    if (capt && trap) m_mode = M_FRZ;
                    else if (!en)     m_mode = M_OFF;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_level",  128'(level),     128'(mq.size()));
            chk("model_valid",  128'(rec_valid), 128'(mq.size() > 0));
            chk("model_ovf",    128'(ovf_cnt),   128'(m_ovf));
            chk("model_frozen", 128'(frozen),    128'(m_mode == M_FRZ));
            if (mq.size() > 0) chk("model_data", 128'(rec_data), 128'(mq[0]));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] p, input logic t);
        valid = 1'b1; pc = p; trap = t; insn = ~p; wdata = p + 32'd1;
        rd_addr = p[6:2]; intr = p[3]; wtag = p[2];
        cyc();
        valid = 1'b0; trap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc [4];
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; valid = 1'b0; trap = 1'b0; intr = 1'b0;
        ready = 1'b0; wtag = 1'b0; rd_addr = '0; pc = '0; insn = '0; wdata = '0;
        cyc(); cyc();
        chk("rst_level", 128'(level), 128'(0));
        chk("rst_valid", 128'(rec_valid), 128'(0));
        chk("rst_ovf", 128'(ovf_cnt), 128'(0));
        chk("rst_frozen", 128'(frozen), 128'(0));
        rst_n = 1'b1; en = 1'b1;
        cyc();

        // Three retirements held, then drained in order.
        put(32'h100, 1'b0); put(32'h104, 1'b0); put(32'h108, 1'b0);
        chk("fill3_level", 128'(level), 128'(3));
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_pc", 128'(rec_data[95:64]), 128'(32'h100 + 32'(4 * i)));
            cyc();
        end
        chk("drain_level", 128'(level), 128'(0));
        chk("drain_valid", 128'(rec_valid), 128'(0));
        ready = 1'b0;

        // Six into a four-deep FIFO: two dropped.
        for (int i = 0; i < 6; i++) put(32'h300 + 32'(4 * i), 1'b0);
        chk("ovf_level", 128'(level), 128'(4));
        chk("ovf_cnt", 128'(ovf_cnt), 128'(2));
        chk("ovf_head", 128'(rec_data[95:64]), 128'(32'h300));

        // Full with push and pop together.
        ready = 1'b1;
        put(32'h400, 1'b0);
        chk("fullpp_level", 128'(level), 128'(4));
        chk("fullpp_ovf", 128'(ovf_cnt), 128'(2));
        exp_pc[0] = 32'h304; exp_pc[1] = 32'h308; exp_pc[2] = 32'h30C; exp_pc[3] = 32'h400;
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_order", 128'(rec_data[95:64]), 128'(exp_pc[i]));
            cyc();
        end

        // Empty with push and pop together: only the push happens.
        put(32'h500, 1'b0);
        chk("emptypp_level", 128'(level), 128'(1));
        chk("emptypp_valid", 128'(rec_valid), 128'(1));
        cyc();
        ready = 1'b0;

        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_ovf", 128'(ovf_cnt), 128'(0));
        cyc();

        // Stop on trap: second record not captured.
        put(32'h200, 1'b1); put(32'h204, 1'b0);
        chk("trap_frozen", 128'(frozen), 128'(1));
        chk("trap_level", 128'(level), 128'(1));
        chk("trap_head", 128'(rec_data[95:64]), 128'(32'h200));
        chk("trap_bit", 128'(rec_data[102]), 128'(1));
        clr = 1'b1; en = 1'b0; cyc(); clr = 1'b0;
        chk("unfrz_level", 128'(level), 128'(0));
        chk("unfrz_frozen", 128'(frozen), 128'(0));
        put(32'h600, 1'b0);
        chk("off_nopush", 128'(level), 128'(0));
        en = 1'b1; cyc();

        // Reset in the middle of draining.
        put(32'h700, 1'b0); put(32'h704, 1'b0);
        ready = 1'b1; cyc();
        rst_n = 1'b0; cyc();
        chk("midrst_valid", 128'(rec_valid), 128'(0));
        chk("midrst_level", 128'(level), 128'(0));
        rst_n = 1'b1; ready = 1'b0; cyc();

        // Mixed traffic exercising every record field.
        for (int i = 0; i < 40; i++) begin
            valid = (i % 3) != 0; trap = 1'b0; intr = i[0]; wtag = i[1];
            pc = 32'h1000 + 32'(4 * i); insn = 32'(i) * 32'h9E3779B9;
            wdata = ~insn; rd_addr = 5'(i * 7); ready = (i % 4) < 2;
            cyc();
        end
        valid = 1'b0; ready = 1'b1;
        repeat (6) cyc();
`ifdef IBEXC_TRACE_CAP_TAG_EN
        ready = 1'b0;
        wtag = 1'b1; valid = 1'b1; pc = 32'h800; cyc(); valid = 1'b0;
        chk("tag_bit", 128'(rec_data[103]), 128'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
